// File: rtl/inst_trace_tx.sv
// Instruction-trace transmitter: captures {pc,inst} on PC change into a FIFO and streams 9-byte frames.
// Optional TRACE_DROP_MARK_EN: a frame that follows any record drop starts with SYNC 0x5A instead of 0xA5.
module inst_trace_tx #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              pc,
  input  logic [31:0]              inst,
  input  logic                     trace_en,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         drop_cnt
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_PC, ST_IR} state_t;

  state_t        state_q, state_d;
  logic [1:0]    bi_q, bi_d;
  logic [63:0]   sh_q, sh_d;
  logic [7:0]    data_d;
  logic          valid_d;
  logic          pop, accept;

  logic [31:0]   last_pc;
  logic          last_vld;
  logic [63:0]   mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          capture, full, empty, push, drop;
  logic [7:0]    sync_byte;

  assign capture    = trace_en && (!last_vld || pc != last_pc);
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push       = capture && !full;
  assign drop       = capture && full;
  assign fifo_level = wr_ptr - rd_ptr;
  assign accept     = tx_valid && tx_ready;

`ifdef TRACE_DROP_MARK_EN
  logic lost;
  assign sync_byte = lost ? 8'h5A : 8'hA5;

  // A drop in the same cycle as the marked frame's pop keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      lost <= 1'b0;
    else if (drop) lost <= 1'b1;
    else if (pop)  lost <= 1'b0;
  end
`else
  assign sync_byte = 8'hA5;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_pc  <= '0;
      last_vld <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      drop_cnt <= '0;
    end else begin
      if (capture) begin
        last_pc  <= pc;
        last_vld <= 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {pc, inst};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      bi_q     <= 2'd0;
      sh_q     <= '0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
    end else begin
      state_q  <= state_d;
      bi_q     <= bi_d;
      sh_q     <= sh_d;
      tx_data  <= data_d;
      tx_valid <= valid_d;
    end
  end

  // Shift register always holds the next byte to present in its top octet.
  always_comb begin
    state_d = state_q;
    bi_d    = bi_q;
    sh_d    = sh_q;
    data_d  = tx_data;
    valid_d = tx_valid;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: if (!empty) begin
        pop     = 1'b1;
        sh_d    = mem[rd_ptr[AW-1:0]];
        data_d  = sync_byte;
        valid_d = 1'b1;
        state_d = ST_SYNC;
      end
      ST_SYNC: if (accept) begin
        data_d  = sh_q[63:56];
        sh_d    = {sh_q[55:0], 8'h00};
        bi_d    = 2'd0;
        state_d = ST_PC;
      end
      ST_PC: if (accept) begin
        data_d = sh_q[63:56];
        sh_d   = {sh_q[55:0], 8'h00};
        if (bi_q == 2'd3) begin
          bi_d    = 2'd0;
          state_d = ST_IR;
        end else begin
          bi_d = bi_q + 2'd1;
        end
      end
      ST_IR: if (accept) begin
        if (bi_q == 2'd3) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          data_d = sh_q[63:56];
          sh_d   = {sh_q[55:0], 8'h00};
          bi_d   = bi_q + 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_inst_trace_tx.sv
// Scoreboard bench for inst_trace_tx: stimulus queues expected frame bytes, a negedge monitor checks the stream.
module tb_inst_trace_tx;
  logic        clk, rst, trace_en, tx_ready, tx_valid;
  logic [31:0] pc, inst;
  logic [7:0]  tx_data;
  logic [3:0]  fifo_level;
  logic [7:0]  drop_cnt;

  inst_trace_tx #(.DEPTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .pc(pc), .inst(inst), .trace_en(trace_en),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .fifo_level(fifo_level), .drop_cnt(drop_cnt)
  );

`ifdef TRACE_DROP_MARK_EN
  localparam logic [7:0] SYNC_MARK = 8'h5A;
`else
  localparam logic [7:0] SYNC_MARK = 8'hA5;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, rx_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push_frame(input logic [7:0] sync, input logic [31:0] p, input logic [31:0] i);
    exp_q.push_back(sync);
    for (int b = 3; b >= 0; b--) exp_q.push_back(p[b*8 +: 8]);
    for (int b = 3; b >= 0; b--) exp_q.push_back(i[b*8 +: 8]);
  endtask

  // Monitor: a byte seen valid&&ready at negedge transfers on the next rising edge.
  logic       stalled = 1'b0;
  logic [7:0] hold = 8'h00;
  int         fidx = 0;
  always @(negedge clk) begin
    if (!rst) begin
      stalled = 1'b0;
      fidx    = 0;
    end else begin
      if (stalled) begin
        chk("stall_valid", tx_valid, 1'b1);
        chk("stall_hold", tx_data, hold);
      end
      if (fidx != 0) chk("frame_continuous", tx_valid, 1'b1);
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) chk("unexpected_byte", tx_data, 9'h100);
        else chk("stream_byte", tx_data, exp_q.pop_front());
        rx_cnt++;
        fidx    = (fidx == 8) ? 0 : fidx + 1;
        stalled = 1'b0;
      end else if (tx_valid) begin
        stalled = 1'b1;
        hold    = tx_data;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b0; trace_en = 1'b0; tx_ready = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic drain(input int max_cyc, input bit rand_rdy);
    for (int c = 0; c < max_cyc && exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
      if (rand_rdy) tx_ready = 1'($urandom_range(0, 1));
    end
    chk("drain_done", exp_q.size(), 0);
    tx_ready = 1'b1;
    repeat (15) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b0; trace_en = 1'b0; tx_ready = 1'b0; pc = '0; inst = '0;
    // Reset values with random inputs
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      pc = $urandom; inst = $urandom;
      trace_en = 1'($urandom_range(0, 1)); tx_ready = 1'($urandom_range(0, 1));
      #2;
      chk("rst_valid", tx_valid, 1'b0);
      chk("rst_data", tx_data, 8'h00);
      chk("rst_level", fifo_level, 4'd0);
      chk("rst_drop", drop_cnt, 8'd0);
    end
    // Release with a constant PC: exactly one frame
    @(posedge clk); #1;
    pc = 32'h0040_0000; inst = 32'h1234_5678; trace_en = 1'b1; tx_ready = 1'b1;
    push_frame(8'hA5, pc, inst);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("lat_level_n1", fifo_level, 4'd1);
    chk("lat_valid_n1", tx_valid, 1'b0);
    @(posedge clk); #1;
    chk("lat_valid_n2", tx_valid, 1'b1);
    chk("lat_sync_n2", tx_data, 8'hA5);
    chk("lat_level_n2", fifo_level, 4'd0);
    drain(40, 0);

    // Ordering: one PC step per 10 cycles
    apply_reset();
    trace_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc = 32'h0040_0000 + 32'(i * 4); inst = 32'hA000_0000 + 32'(i);
      push_frame(8'hA5, pc, inst);
      repeat (10) @(posedge clk);
      #1;
    end
    drain(60, 0);

    // Backpressure: two queued records, random ready
    pc = 32'h0050_0000; inst = 32'hDEAD_BEEF; push_frame(8'hA5, pc, inst);
    @(posedge clk); #1;
    pc = 32'h0050_0010; inst = 32'h0102_0304; push_frame(8'hA5, pc, inst);
    @(posedge clk); #1;
    drain(400, 1);

    // Overflow: 13 captures with ready low; record 0 sits in the shift register
    apply_reset();
    tx_ready = 1'b0; trace_en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      pc = 32'h0060_0000 + 32'(i * 4); inst = ~pc;
      if (i <= 8) push_frame((i == 1) ? SYNC_MARK : 8'hA5, pc, inst);
      @(posedge clk); #1;
    end
    chk("ovf_level", fifo_level, 4'd8);
    chk("ovf_drop", drop_cnt, 8'd4);
    chk("ovf_held_valid", tx_valid, 1'b1);
    chk("ovf_held_sync", tx_data, 8'hA5);
    tx_ready = 1'b1;
    drain(200, 0);
    chk("ovf_level_end", fifo_level, 4'd0);
    chk("ovf_drop_end", drop_cnt, 8'd4);

    // Saturation: 310 captures, 9 absorbed
    apply_reset();
    tx_ready = 1'b0; trace_en = 1'b1;
    for (int i = 0; i < 310; i++) begin
      pc = 32'h0070_0000 + 32'(i * 4); inst = pc;
      @(posedge clk); #1;
    end
    chk("sat_drop", drop_cnt, 8'hFF);
    chk("sat_level", fifo_level, 4'd8);

    // Mid-frame reset after byte 3
    apply_reset();
    pc = 32'h0080_0000; inst = 32'hCAFE_F00D; trace_en = 1'b1;
    push_frame(8'hA5, pc, inst);
    base = rx_cnt;
    for (int c = 0; c < 50 && rx_cnt < base + 4; c++) @(posedge clk);
    chk("mid_reach_byte3", rx_cnt - base, 4);
    #1 trace_en = 1'b0; rst = 1'b0;
    #1;
    chk("mid_valid_async", tx_valid, 1'b0);
    chk("mid_data_async", tx_data, 8'h00);
    chk("mid_level_async", fifo_level, 4'd0);
    chk("mid_drop_async", drop_cnt, 8'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("mid_idle", tx_valid, 1'b0);
    pc = 32'h0090_0000; inst = 32'h0BAD_BEEF; trace_en = 1'b1;
    push_frame(8'hA5, pc, inst);
    drain(40, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
